// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I MEM stage: req/ack data-memory access FSM, lane formatting, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: suppress misaligned accesses and retire them without a register write.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        m_valid,
   input  logic        m_mem_read,
   input  logic        m_mem_write,
   input  logic [1:0]  m_mem_size,
   input  logic        m_mem_unsigned,
   input  logic [31:0] m_alu_out,
   input  logic [31:0] m_mem_data,
   input  logic [31:0] m_pc_inc,
   input  logic [1:0]  m_wb_sel,
   input  logic [4:0]  m_rd,
   input  logic        m_reg_write,
   output logic [31:0] m_forward_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        mem_misalign,
   output logic        w_valid,
   output logic        w_reg_write,
   output logic [4:0]  w_rd,
   output logic [31:0] w_data
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state_q, state_d;
   logic [29:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        we_q, we_d;
   logic [1:0]  lo_q, lo_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] ld_q, ld_d;
   logic        w_valid_q, w_valid_d;
   logic        w_reg_write_q, w_reg_write_d;
   logic [4:0]  w_rd_q, w_rd_d;
   logic [31:0] w_data_q, w_data_d;

   logic        is_mem;
   logic        issue;
   logic        trap;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_fmt;

   assign is_mem = m_mem_read | m_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = ((m_mem_size == 2'b01) & m_alu_out[0]) |
                       (m_mem_size[1] & (m_alu_out[1:0] != 2'b00));
   assign trap  = (state_q == IDLE) & m_valid & is_mem & misaligned;
   assign issue = m_valid & is_mem & ~misaligned;
`else
   assign trap  = 1'b0;
   assign issue = m_valid & is_mem;
`endif

   assign mem_misalign   = trap;
   assign m_forward_data = (m_wb_sel == 2'b10) ? m_pc_inc : m_alu_out;

   // Store lane steering; size 11 falls through to word.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = m_mem_data;
      case (m_mem_size)
         2'b00: begin
            st_be    = 4'b0001 << m_alu_out[1:0];
            st_wdata = {4{m_mem_data[7:0]}};
         end
         2'b01: begin
            st_be    = m_alu_out[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{m_mem_data[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = m_mem_data;
         end
      endcase
   end

   // Load lane select uses the address bits latched at issue.
   always_comb begin
      ld_byte = dmem_rdata[7:0];
      case (lo_q)
         2'b00:   ld_byte = dmem_rdata[7:0];
         2'b01:   ld_byte = dmem_rdata[15:8];
         2'b10:   ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (size_q)
         2'b00:   ld_fmt = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
         2'b01:   ld_fmt = {{16{ld_half[15] & ~uns_q}}, ld_half};
         default: ld_fmt = dmem_rdata;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      we_d      = we_q;
      lo_d      = lo_q;
      size_d    = size_q;
      uns_d     = uns_q;
      ld_d      = ld_q;
      mem_stall = 1'b0;
      dmem_req  = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               addr_d    = m_alu_out[31:2];
               lo_d      = m_alu_out[1:0];
               size_d    = m_mem_size;
               uns_d     = m_mem_unsigned;
               we_d      = m_mem_write;
               be_d      = m_mem_write ? st_be : 4'b1111;
               wdata_d   = m_mem_write ? st_wdata : 32'h0;
               mem_stall = 1'b1;
               state_d   = BUSY;
            end
         end
         BUSY: begin
            dmem_req  = 1'b1;
            mem_stall = 1'b1;
            if (dmem_ack) begin
               ld_d    = ld_fmt;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      w_valid_d     = mem_stall ? 1'b0 : m_valid;
      w_reg_write_d = mem_stall ? 1'b0 : (m_reg_write & m_valid & ~trap);
      w_rd_d        = m_rd;
      case (m_wb_sel)
         2'b01:   w_data_d = ld_q;
         2'b10:   w_data_d = m_pc_inc;
         default: w_data_d = m_alu_out;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= 30'h0;
         wdata_q       <= 32'h0;
         be_q          <= 4'h0;
         we_q          <= 1'b0;
         lo_q          <= 2'b00;
         size_q        <= 2'b00;
         uns_q         <= 1'b0;
         ld_q          <= 32'h0;
         w_valid_q     <= 1'b0;
         w_reg_write_q <= 1'b0;
         w_rd_q        <= 5'h0;
         w_data_q      <= 32'h0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         be_q          <= be_d;
         we_q          <= we_d;
         lo_q          <= lo_d;
         size_q        <= size_d;
         uns_q         <= uns_d;
         ld_q          <= ld_d;
         w_valid_q     <= w_valid_d;
         w_reg_write_q <= w_reg_write_d;
         w_rd_q        <= w_rd_d;
         w_data_q      <= w_data_d;
      end
   end

   assign dmem_we     = we_q;
   assign dmem_addr   = {addr_q, 2'b00};
   assign dmem_be     = be_q;
   assign dmem_wdata  = wdata_q;
   assign w_valid     = w_valid_q;
   assign w_reg_write = w_reg_write_q;
   assign w_rd        = w_rd_q;
   assign w_data      = w_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed bench for mem_stage; honours MEM_MISALIGN_TRAP_EN.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_valid = 1'b0, m_mem_read = 1'b0, m_mem_write = 1'b0;
   logic [1:0]  m_mem_size = 2'b00;
   logic        m_mem_unsigned = 1'b0;
   logic [31:0] m_alu_out = 32'h0, m_mem_data = 32'h0, m_pc_inc = 32'h0;
   logic [1:0]  m_wb_sel = 2'b00;
   logic [4:0]  m_rd = 5'h0;
   logic        m_reg_write = 1'b0;
   logic [31:0] m_forward_data;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'h0;
   logic        mem_stall, mem_misalign;
   logic        w_valid, w_reg_write;
   logic [4:0]  w_rd;
   logic [31:0] w_data;

   int total = 0;
   int bad   = 0;

   mem_stage dut (
      .clk(clk), .rst(rst), .m_valid(m_valid), .m_mem_read(m_mem_read),
      .m_mem_write(m_mem_write), .m_mem_size(m_mem_size), .m_mem_unsigned(m_mem_unsigned),
      .m_alu_out(m_alu_out), .m_mem_data(m_mem_data), .m_pc_inc(m_pc_inc),
      .m_wb_sel(m_wb_sel), .m_rd(m_rd), .m_reg_write(m_reg_write),
      .m_forward_data(m_forward_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
      .mem_misalign(mem_misalign), .w_valid(w_valid), .w_reg_write(w_reg_write),
      .w_rd(w_rd), .w_data(w_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic        rw;
      logic [31:0] e_fwd;
      logic [31:0] e_data;
      logic        e_v;
      logic        e_rw;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic mem_op(input string nm, input logic rd_en, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] rd, input int ack_at, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_w);
      int  stalls = 0;
      int  busy   = 0;
      bit  done   = 0;
      m_valid = 1'b1; m_mem_read = rd_en; m_mem_write = ~rd_en;
      m_mem_size = size; m_mem_unsigned = uns; m_alu_out = addr; m_mem_data = sdata;
      m_pc_inc = 32'h0; m_wb_sel = rd_en ? 2'b01 : 2'b00; m_rd = rd; m_reg_write = rd_en;
      for (int i = 0; i < 30 && !done; i++) begin
         if (i == 0) begin
            chk({nm, " req_idle"}, {31'h0, dmem_req}, 32'h0);
            chk({nm, " misalign"}, {31'h0, mem_misalign}, 32'h0);
         end
         if (dmem_req) begin
            busy++;
            chk({nm, " addr"}, dmem_addr, e_addr);
            chk({nm, " be"}, {28'h0, dmem_be}, {28'h0, e_be});
            chk({nm, " we"}, {31'h0, dmem_we}, {31'h0, ~rd_en});
            if (!rd_en) chk({nm, " wdata"}, dmem_wdata, e_wdata);
            if (busy == ack_at) begin
               dmem_ack = 1'b1;
               dmem_rdata = rdata;
            end
         end
         @(negedge clk);
         if (mem_stall) stalls++;
         else done = 1;
         if (!done) begin
            @(posedge clk); #1;
            dmem_ack = 1'b0;
         end
      end
      chk({nm, " completed"}, {31'h0, done}, 32'h1);
      chk({nm, " stall_cycles"}, stalls, ack_at + 1);
      @(posedge clk); #1;
      chk({nm, " w_valid"}, {31'h0, w_valid}, 32'h1);
      chk({nm, " w_reg_write"}, {31'h0, w_reg_write}, {31'h0, rd_en});
      chk({nm, " w_rd"}, {27'h0, w_rd}, {27'h0, rd});
      chk({nm, " w_data"}, w_data, e_w);
      m_valid = 1'b0; m_mem_read = 1'b0; m_mem_write = 1'b0;
   endtask

   initial begin
      //            v     alu            pc            sel    rd     rw    e_fwd          e_data         e_v   e_rw
      vecs[0] = '{1'b1, 32'h0000_1234, 32'h0000_0010, 2'b00, 5'd5,  1'b1, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1};
      vecs[1] = '{1'b1, 32'h0000_4000, 32'h0000_0104, 2'b10, 5'd1,  1'b1, 32'h0000_0104, 32'h0000_0104, 1'b1, 1'b1};
      vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'h0000_0200, 2'b00, 5'd9,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 32'h1357_9BDF, 32'h0000_0300, 2'b11, 5'd31, 1'b1, 32'h1357_9BDF, 32'h1357_9BDF, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 32'hFFFF_0000, 32'h0000_0400, 2'b00, 5'd0,  1'b0, 32'hFFFF_0000, 32'hFFFF_0000, 1'b1, 1'b0};

      #12;
      chk("rst dmem_req", {31'h0, dmem_req}, 32'h0);
      chk("rst mem_stall", {31'h0, mem_stall}, 32'h0);
      chk("rst w_valid", {31'h0, w_valid}, 32'h0);
      chk("rst w_data", w_data, 32'h0);
      chk("rst dmem_be", {28'h0, dmem_be}, 32'h0);
      chk("rst dmem_addr", dmem_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         m_valid = vecs[i].v; m_alu_out = vecs[i].alu; m_pc_inc = vecs[i].pc;
         m_wb_sel = vecs[i].sel; m_rd = vecs[i].rd; m_reg_write = vecs[i].rw;
         m_mem_read = 1'b0; m_mem_write = 1'b0;
         @(negedge clk);
         chk($sformatf("vec%0d stall", i), {31'h0, mem_stall}, 32'h0);
         chk($sformatf("vec%0d fwd", i), m_forward_data, vecs[i].e_fwd);
         @(posedge clk); #1;
         chk($sformatf("vec%0d w_valid", i), {31'h0, w_valid}, {31'h0, vecs[i].e_v});
         chk($sformatf("vec%0d w_reg_write", i), {31'h0, w_reg_write}, {31'h0, vecs[i].e_rw});
         chk($sformatf("vec%0d w_rd", i), {27'h0, w_rd}, {27'h0, vecs[i].rd});
         chk($sformatf("vec%0d w_data", i), w_data, vecs[i].e_data);
      end
      m_valid = 1'b0;

      //      name    rd    size   uns   addr          sdata          rd    ack rdata          e_addr         e_be     e_wdata        e_w
      mem_op("SB",   1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'hAABB_CCDD, 5'd0, 1, 32'h0,         32'h0000_0100, 4'b0100, 32'hDDDD_DDDD, 32'h0000_0102);
      mem_op("LB",   1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h0,         5'd6, 3, 32'h80FF_0000, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_FF80);
      mem_op("LBU",  1'b1, 2'b00, 1'b1, 32'h0000_0103, 32'h0,         5'd6, 3, 32'h80FF_0000, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_0080);
      mem_op("LH",   1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0,         5'd7, 1, 32'h1234_5678, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_1234);
      mem_op("SH",   1'b0, 2'b01, 1'b0, 32'h0000_0106, 32'h0000_BEEF, 5'd0, 2, 32'h0,         32'h0000_0104, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0106);
      mem_op("SW",   1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h1122_3344, 5'd0, 1, 32'h0,         32'h0000_0200, 4'b1111, 32'h1122_3344, 32'h0000_0200);
      mem_op("LH_n", 1'b1, 2'b01, 1'b0, 32'h0000_0100, 32'h0,         5'd8, 1, 32'h0000_F00D, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_F00D);
      mem_op("LHU",  1'b1, 2'b01, 1'b1, 32'h0000_0100, 32'h0,         5'd8, 1, 32'h0000_F00D, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_F00D);
      mem_op("LB1",  1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0,         5'd9, 1, 32'h0000_7F00, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_007F);
      mem_op("SB3",  1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_005A, 5'd0, 1, 32'h0,         32'h0000_0010, 4'b1000, 32'h5A5A_5A5A, 32'h0000_0013);
      mem_op("LW11", 1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h0,         5'd3, 1, 32'hCAFE_F00D, 32'h0000_0010, 4'b1111, 32'h0,         32'hCAFE_F00D);

`ifdef MEM_MISALIGN_TRAP_EN
      m_valid = 1'b1; m_mem_read = 1'b1; m_mem_write = 1'b0; m_mem_size = 2'b10;
      m_alu_out = 32'h0000_0101; m_wb_sel = 2'b01; m_rd = 5'd7; m_reg_write = 1'b1;
      @(negedge clk);
      chk("trap misalign", {31'h0, mem_misalign}, 32'h1);
      chk("trap stall", {31'h0, mem_stall}, 32'h0);
      chk("trap req", {31'h0, dmem_req}, 32'h0);
      @(posedge clk); #1;
      m_valid = 1'b0; m_mem_read = 1'b0;
      chk("trap w_valid", {31'h0, w_valid}, 32'h1);
      chk("trap w_reg_write", {31'h0, w_reg_write}, 32'h0);
      chk("trap no_req", {31'h0, dmem_req}, 32'h0);
      chk("trap pulse", {31'h0, mem_misalign}, 32'h0);
`else
      mem_op("LWmis", 1'b1, 2'b10, 1'b0, 32'h0000_0101, 32'h0, 5'd7, 1, 32'hCAFE_BABE, 32'h0000_0100, 4'b1111, 32'h0, 32'hCAFE_BABE);
      mem_op("LHmis", 1'b1, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h8001_0000, 32'h0000_0100, 4'b1111, 32'h0, 32'hFFFF_8001);
`endif

      m_valid = 1'b1; m_mem_read = 1'b1; m_mem_write = 1'b0; m_mem_size = 2'b10;
      m_alu_out = 32'h0000_0300; m_wb_sel = 2'b01; m_rd = 5'd4; m_reg_write = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid req_before", {31'h0, dmem_req}, 32'h1);
      m_valid = 1'b0; m_mem_read = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_mid req_drop", {31'h0, dmem_req}, 32'h0);
      chk("rst_mid stall", {31'h0, mem_stall}, 32'h0);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         chk($sformatf("late_ack cyc%0d", i), {30'h0, w_valid, dmem_req}, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage RV32I pipeline, directly downstream of the execute stage. Takes the EX/MEM-registered ALU result, store data and PC+4, performs byte/halfword/word loads and stores over a req/ack data-memory bus, stalls the pipeline until the access completes, and registers the MEM/WB result. Also drives the combinational MEM-stage forwarding value that execute consumes as `ex_m_data`.

## Interface
- No parameters.
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `m_valid` in 1: an instruction occupies MEM.
- `m_mem_read`, `m_mem_write` in 1 each: load / store. Never both set.
- `m_mem_size` in 2: 00 byte, 01 half, 10 word. 11 is treated as word.
- `m_mem_unsigned` in 1: zero-extend loads (LBU/LHU).
- `m_alu_out` in 32: ALU result / effective address.
- `m_mem_data` in 32: store data, already forwarded.
- `m_pc_inc` in 32: PC+4.
- `m_wb_sel` in 2: 00 ALU, 01 load, 10 PC+4.
- `m_rd` in 5, `m_reg_write` in 1: destination register and write enable.
- `m_forward_data` out 32: combinational; `m_pc_inc` if `m_wb_sel`=10, else `m_alu_out`.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (bits [1:0]=0), `dmem_be` out 4, `dmem_wdata` out 32.
- `dmem_ack` in 1, `dmem_rdata` in 32: completion strobe and read word.
- `mem_stall` out 1: freeze IF..EX/MEM registers.
- `mem_misalign` out 1: misaligned-access flag.
- `w_valid`, `w_reg_write` out 1 each; `w_rd` out 5; `w_data` out 32: MEM/WB register.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `m_valid` and (read or write) and the access is issuable, latch address, we, be and wdata into bus registers.
  - Then go to BUSY with `mem_stall`=1.
  - Otherwise stay in IDLE with `mem_stall`=0.
- BUSY:
  - `dmem_req`=1 while in BUSY. Bus outputs are driven from the bus registers and held stable.
  - On `dmem_ack`, capture the formatted load data into `ld_q` and go to DONE. `mem_stall` stays 1.
- DONE: `mem_stall`=0; go to IDLE. The MEM/WB register captures this instruction at the end of the DONE cycle.
- `dmem_ack` outside BUSY is ignored.
- MEM/WB register updates every cycle.
  - While `mem_stall`=1: `w_valid`=0 and `w_reg_write`=0 (bubble).
  - Otherwise it takes `m_valid`, `m_rd`, and `m_reg_write & m_valid`.
  - `w_data` selects by `m_wb_sel`: ALU, `ld_q`, or PC+4.
- Store lanes:
  - Byte: `dmem_be` = 0001 shifted by addr[1:0]; wdata = byte replicated ×4.
  - Half: `dmem_be` = 0011 or 1100 by addr[1]; wdata = half replicated ×2.
  - Word: `dmem_be` = 1111.
- Loads: `dmem_we`=0 and `dmem_be`=1111. Select the lane by addr[1:0], then sign-extend, or zero-extend when `m_mem_unsigned`=1.
- `dmem_addr` = {addr[31:2], 2'b00}.

## Timing
- Reset values: state IDLE; `dmem_req`, `dmem_we`, `mem_stall`, `mem_misalign`, `w_valid`, `w_reg_write` all 0; `w_rd` 0; `w_data`, `dmem_addr`, `dmem_be`, `dmem_wdata` all 0.
- `rst` mid-access drops `dmem_req` immediately (asynchronous) and abandons the access. A later `dmem_ack` is ignored.
- Non-memory instruction: 0 stall cycles; result appears on `w_*` the cycle after entry.
- Memory access, ack in first BUSY cycle: `mem_stall` high for 2 cycles (IDLE entry cycle, BUSY). Result appears on `w_*` one cycle after DONE. Each extra ack wait cycle adds one stall cycle.
- `mem_stall` is combinational from state and inputs. In IDLE it depends on `m_valid`, `m_mem_read`/`m_mem_write` and the address.
- Back-to-back accesses: DONE→IDLE costs one cycle, then the new access begins.

## Configuration
- Macro `MEM_MISALIGN_TRAP_EN`.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.
- Defined:
  - A misaligned access is not issued; no bus traffic.
  - `mem_misalign` pulses 1 for that cycle and `mem_stall`=0.
  - The instruction retires with `w_reg_write`=0 and `w_valid`=1.
- Not defined:
  - `mem_misalign` is tied to 0.
  - Misaligned accesses issue with the low bits ignored: word uses addr[31:2]; half uses the addr[1] lane.

## Test plan
- ADD result 0x0000_1234, `m_wb_sel`=00, rd=5 → no stall; next cycle `w_data`=0x1234, `w_rd`=5, `w_reg_write`=1.
- SB data 0xAABBCCDD to addr 0x102 → `dmem_be`=0100, `dmem_wdata`=0xDDDDDDDD, `dmem_addr`=0x100, `dmem_we`=1, req held until ack.
- LB from addr 0x103, rdata 0x80FF_0000, ack after 3 BUSY cycles → `mem_stall` high 4 cycles; `w_data`=0xFFFF_FF80. LBU of the same access → 0x0000_0080.
- LH from 0x102 with rdata 0x1234_5678 → 0x0000_1234. Store immediately following → one idle cycle, then second req.
- Assert `rst` in BUSY → `dmem_req` 0 same cycle, state IDLE; late `dmem_ack` causes no `w_valid`.
- With `MEM_MISALIGN_TRAP_EN`: LW from 0x101 → `mem_misalign`=1 for one cycle, no `dmem_req`, `w_reg_write`=0.
